// File: rtl/axis_packetizer_pkg.sv
// ============================================================================
// Module      : packetizer_pkg
// Description : Shared types and sizing helpers for the AXI-Stream
//               packetizer: FSM state encoding, default sizing constants
//               and functions to derive them from module parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package packetizer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEQ  = 3'd1,
    DATA = 3'd2,
    PAD  = 3'd3,
    DONE = 3'd4
  } packetizer_state_t;

  // Values for the default configuration (4-byte sequence over 1-byte words,
  // one-million-cycle timeout). Instances derive their own with the
  // functions below.
  localparam int SEQ_WORDS = 4;
  localparam int TIMEOUT_W = $clog2(1000000 + 1);

  function automatic int seq_words_f(input int seq_bytes, input int word_bytes);
    return seq_bytes / word_bytes;
  endfunction

  function automatic int timeout_w_f(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_packetizer_pipe_reg.sv
// ============================================================================
// Module      : axis_pipe_reg
// Description : Single-entry registered AXI-Stream stage. A new beat is
//               taken whenever the register is empty or its current beat is
//               being accepted downstream (load = !out_valid || out_ready).
//               Data and last hold while out_valid is high and out_ready low.
// Ports       : clk, rst_n        clock, async active-low reset
//               in_data/in_last   beat offered by the producer
//               in_valid          producer has a beat this cycle
//               load              stage can take a beat this cycle
//               out_data/out_last registered beat
//               out_valid         registered beat is valid
//               out_ready         downstream accepts the beat
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              load,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  assign load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_packetizer.sv
// ============================================================================
// Module      : axis_packetizer
// Description : Cuts a continuous AXI-Stream sample flow into fixed-length
//               packets. Each packet is a big-endian sequence number followed
//               by payload samples; a stalled packet is completed with pad
//               words after an idle timeout or an explicit flush.
// Ports       : clk, rst_n      clock, async active-low reset
//               s_axis_*        sample input (tdata, tvalid, tready)
//               m_axis_*        packet output (tdata, tvalid, tlast, tready)
//               flush           one-cycle request to pad the current packet
//               seq_num         sequence number of the next/current packet
//               pad_count       number of padded packets, saturating
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_packetizer
  import packetizer_pkg::*;
#(
  parameter int PACKET_PAYLOAD_WORDS = 64,
  parameter int WORD_BYTES           = 1,
  parameter int SEQ_BYTES            = 4,
  parameter int TIMEOUT_CYCLES       = 1000000,
  parameter logic [WORD_BYTES*8-1:0] PAD_WORD = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_BYTES*8-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [WORD_BYTES*8-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic                    flush,
  output logic [SEQ_BYTES*8-1:0]  seq_num,
  output logic [15:0]             pad_count
);

  localparam int WORD_BITS   = WORD_BYTES * 8;
  localparam int SEQ_BITS    = SEQ_BYTES * 8;
  localparam int N_SEQ_WORDS = seq_words_f(SEQ_BYTES, WORD_BYTES);
  localparam int N_TO_W      = timeout_w_f(TIMEOUT_CYCLES);
  localparam int CNT_W       = (PACKET_PAYLOAD_WORDS > 1) ? $clog2(PACKET_PAYLOAD_WORDS) : 1;

  localparam logic [CNT_W-1:0]  LAST_CNT     = CNT_W'(PACKET_PAYLOAD_WORDS - 1);
  localparam logic [CNT_W-1:0]  SEQ_LAST_CNT = CNT_W'(N_SEQ_WORDS - 1);
  localparam logic [N_TO_W-1:0] TO_LIMIT     = N_TO_W'(TIMEOUT_CYCLES);

  packetizer_state_t state;
  logic [CNT_W-1:0]  word_cnt;
  logic [N_TO_W-1:0] to_cnt;
  logic [SEQ_BITS-1:0] seq_r;
  logic [15:0]       pad_r;

  logic [WORD_BITS-1:0] seq_word;
  logic [WORD_BITS-1:0] pipe_data;
  logic                 pipe_last;
  logic                 pipe_valid;
  logic                 load;
  logic                 accept;
  logic                 is_last;
  logic                 to_hit;
  logic                 tlast_taken;

  assign seq_num   = seq_r;
  assign pad_count = pad_r;

  assign is_last       = (word_cnt == LAST_CNT);
  assign s_axis_tready = (state == DATA) && load;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign to_hit        = (to_cnt == TO_LIMIT);
  assign tlast_taken   = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Sequence words go out most significant first; word_cnt doubles as the
  // header word index because the header always opens the packet.
  always_comb begin
    seq_word = '0;
    for (int i = 0; i < N_SEQ_WORDS; i++) begin
      if (word_cnt == CNT_W'(i)) begin
        seq_word = seq_r[(N_SEQ_WORDS-1-i)*WORD_BITS +: WORD_BITS];
      end
    end
  end

  always_comb begin
    pipe_valid = 1'b0;
    pipe_data  = PAD_WORD;
    pipe_last  = is_last;
    case (state)
      SEQ: begin
        pipe_valid = 1'b1;
        pipe_data  = seq_word;
      end
      DATA: begin
        pipe_valid = s_axis_tvalid;
        pipe_data  = s_axis_tdata;
      end
      PAD: begin
        pipe_valid = 1'b1;
        pipe_data  = PAD_WORD;
      end
      default: begin
        pipe_valid = 1'b0;
      end
    endcase
  end

  axis_pipe_reg #(
    .DATA_W (WORD_BITS)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (pipe_data),
    .in_last   (pipe_last),
    .in_valid  (pipe_valid),
    .load      (load),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      to_cnt   <= '0;
      seq_r    <= '0;
      pad_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          word_cnt <= '0;
          to_cnt   <= '0;
          if (s_axis_tvalid) begin
            state <= SEQ;
          end
        end

        SEQ: begin
          if (load) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (word_cnt == SEQ_LAST_CNT) begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          // A final-word acceptance wins over flush/timeout so that a packet
          // completed by real data is never counted as padded.
          if (accept && is_last) begin
            state    <= DONE;
            word_cnt <= '0;
            to_cnt   <= '0;
          end else if (flush || to_hit) begin
            state  <= PAD;
            to_cnt <= '0;
            if (pad_r != 16'hFFFF) begin
              pad_r <= pad_r + 16'd1;
            end
            if (accept) begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end else if (accept) begin
            word_cnt <= word_cnt + CNT_W'(1);
            to_cnt   <= '0;
          end else if (!s_axis_tvalid) begin
            to_cnt <= to_cnt + N_TO_W'(1);
          end
        end

        PAD: begin
          if (load) begin
            if (is_last) begin
              state    <= DONE;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end

        DONE: begin
          if (tlast_taken) begin
            state <= IDLE;
            seq_r <= seq_r + SEQ_BITS'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_packetizer.sv
// ============================================================================
// Module      : tb_axis_packetizer
// Description : Directed bench for axis_packetizer with a queue scoreboard.
//               Stimulus pushes the expected packet beats; an independent
//               monitor pops and compares every accepted output beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_packetizer;

  localparam int P  = 8;
  localparam int WB = 1;
  localparam int SB = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] seq_num;
  logic [15:0] pad_count;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          rnd_ready = 1'b0;
  logic [8:0]  exp_q[$];
  logic [8:0]  held = '0;
  bit          holding = 1'b0;

  always #5 clk = ~clk;

  axis_packetizer #(
    .PACKET_PAYLOAD_WORDS (P),
    .WORD_BYTES           (WB),
    .SEQ_BYTES            (SB),
    .TIMEOUT_CYCLES       (TO),
    .PAD_WORD             (8'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .flush         (flush),
    .seq_num       (seq_num),
    .pad_count     (pad_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    m_tready = rnd_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
  end

  // Monitor: compare accepted beats against the scoreboard and check that a
  // stalled beat does not change until it is taken.
  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else if (m_tvalid) begin
      if (holding) chk("hold_stable", {55'd0, m_tlast, m_tdata}, {55'd0, held});
      if (m_tready) begin
        holding = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none", {m_tlast, m_tdata});
        end else begin
          chk("beat", {55'd0, m_tlast, m_tdata}, {55'd0, exp_q.pop_front()});
        end
      end else begin
        holding = 1'b1;
        held    = {m_tlast, m_tdata};
      end
    end
  end

  task automatic push_pkt(input logic [31:0] s, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    exp_q.push_back({1'b0, s[31:24]});
    exp_q.push_back({1'b0, s[23:16]});
    exp_q.push_back({1'b0, s[15:8]});
    exp_q.push_back({1'b0, s[7:0]});
    exp_q.push_back({1'b0, d0});
    exp_q.push_back({1'b0, d1});
    exp_q.push_back({1'b0, d2});
    exp_q.push_back({1'b1, d3});
  endtask

  // Offer one sample (optionally with flush) and return just after the edge
  // that accepted it; tvalid stays high for back-to-back calls.
  task automatic send(input logic [7:0] d, input bit fl);
    bit got;
    bit done;
    done     = 1'b0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    flush    = fl;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      got = s_tready;
      @(posedge clk);
      #1;
      if (got) done = 1'b1;
    end
    flush = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_m_tdata", {56'd0, m_tdata}, 64'd0);
    chk("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_seq_num", {32'd0, seq_num}, 64'd0);
    chk("rst_pad_count", {48'd0, pad_count}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Continuous samples, downstream always ready
    push_pkt(32'd0, 8'h10, 8'h11, 8'h12, 8'h13);
    push_pkt(32'd1, 8'h14, 8'h15, 8'h16, 8'h17);
    for (int d = 8'h10; d <= 8'h17; d++) send(8'(d), 1'b0);
    s_tvalid = 1'b0;
    drain();
    chk("s1_seq_num", {32'd0, seq_num}, 64'd2);

    // Same flow under random downstream backpressure
    rnd_ready = 1'b1;
    push_pkt(32'd2, 8'h10, 8'h11, 8'h12, 8'h13);
    push_pkt(32'd3, 8'h14, 8'h15, 8'h16, 8'h17);
    for (int d = 8'h10; d <= 8'h17; d++) send(8'(d), 1'b0);
    s_tvalid = 1'b0;
    drain();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("s2_seq_num", {32'd0, seq_num}, 64'd4);

    // Input stalls after two samples: timeout pads the remainder
    push_pkt(32'd4, 8'hAA, 8'hBB, 8'h00, 8'h00);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    s_tvalid = 1'b0;
    drain();
    chk("s3_pad_count", {48'd0, pad_count}, 64'd1);
    chk("s3_seq_num", {32'd0, seq_num}, 64'd5);

    // Flush together with the third sample
    push_pkt(32'd5, 8'hAA, 8'hBB, 8'hCC, 8'h00);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    s_tvalid = 1'b0;
    drain();
    chk("s4a_pad_count", {48'd0, pad_count}, 64'd2);

    // Flush together with the final data word: packet ends normally
    push_pkt(32'd6, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    send(8'hD0, 1'b0);
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b1);
    s_tvalid = 1'b0;
    drain();
    chk("s4b_pad_count", {48'd0, pad_count}, 64'd2);
    chk("s4b_seq_num", {32'd0, seq_num}, 64'd7);

    // Asynchronous reset in the middle of a packet
    push_pkt(32'd7, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    send(8'hE0, 1'b0);
    send(8'hE1, 1'b0);
    chk("s6_pre_m_tvalid", {63'd0, m_tvalid}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("s6_m_tdata", {56'd0, m_tdata}, 64'd0);
    chk("s6_m_tlast", {63'd0, m_tlast}, 64'd0);
    chk("s6_s_tready", {63'd0, s_tready}, 64'd0);
    chk("s6_seq_num", {32'd0, seq_num}, 64'd0);
    chk("s6_pad_count", {48'd0, pad_count}, 64'd0);
    exp_q.delete();
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_pkt(32'd0, 8'hF0, 8'hF1, 8'hF2, 8'hF3);
    for (int d = 8'hF0; d <= 8'hF3; d++) send(8'(d), 1'b0);
    s_tvalid = 1'b0;
    drain();
    chk("s6_post_seq_num", {32'd0, seq_num}, 64'd1);

    // Sequence number wrap
    force dut.seq_r = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.seq_r;
    @(posedge clk);
    #1;
    chk("s5_pre_seq_num", {32'd0, seq_num}, 64'hFFFF_FFFF);
    push_pkt(32'hFFFF_FFFF, 8'h50, 8'h51, 8'h52, 8'h53);
    for (int d = 8'h50; d <= 8'h53; d++) send(8'(d), 1'b0);
    s_tvalid = 1'b0;
    drain();
    chk("s5_wrap_seq_num", {32'd0, seq_num}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
